sumatoria_ctrl: RTL and testbench
=================================

# sumatoria_ctrl

Sequencing controller that accumulates one window of SAMPLES*OSF unsigned samples through a single shared two-operand adder and presents the window total with a valid/ready handshake. It sits between the oversampled sample stream and downstream averaging/decision logic. It owns the accumulator register, the window counter and the input/output flow control.

## Interface
- SAMPLES, 128: samples per window before oversampling; power of two.
- OSF, 8: oversampling factor; power of two; window length N = SAMPLES*OSF.
- SIZE, 7: sample MSB index; samples are SIZE+1 bits, unsigned.
- Derived constants: ACC_W = $clog2(N)+SIZE+1 (accumulator/result width); CNT_W = $clog2(N)+1.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request to begin a window; honoured only in IDLE.
- Din  in  SIZE+1  sample.
- Din_valid  in  1  Din is valid.
- Din_ready  out  1  controller accepts Din this cycle.
- Sum  out  ACC_W  window total, registered.
- Sum_valid  out  1  Sum holds a completed window.
- Sum_ready  in  1  downstream accepts Sum.
- Busy  out  1  state is not IDLE.
- Count  out  CNT_W  samples accepted in the current window.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: Din_ready=0, Sum_valid=0, Busy=0. Start=1 -> clear accumulator and Count to 0, go to ACCUM.
- ACCUM: Din_ready=1. Each cycle with Din_valid&&Din_ready: acc <= acc + zero-extended Din, Count <= Count+1. When the accepted sample is the N-th (Count==N-1 before the increment) -> go to DONE.
- DONE: Din_ready=0, Sum_valid=1, Sum/Count held stable. Sum_ready=1 -> go to IDLE.
- Start is ignored in ACCUM and DONE (no restart, no effect on acc).
- Arithmetic: adder output is ACC_W+1 bits; the low ACC_W bits are stored. No overflow is possible because N is a power of two (max N*(2^(SIZE+1)-1) < 2^ACC_W). The MSB is dropped without a flag.
- Din_valid low in ACCUM: hold acc and Count; no timeout.
- Sum is the accumulator register itself; its value is meaningful only while Sum_valid=1.

## Timing
- Reset values: state IDLE, Din_ready=0, Sum=0, Sum_valid=0, Busy=0, Count=0.
- RST has priority over every other input, in any state. Reset mid-window discards the partial sum; the next cycle is IDLE.
- Start sampled at edge k -> Din_ready=1 from cycle k+1.
- Latency: the N-th sample accepted at edge k -> Sum_valid=1 and final Sum visible after edge k (cycle k+1).
- Minimum window time with continuous Din_valid: 1 (Start) + N (accept) + 1 (handshake) cycles.
- Sum_valid stays high until the edge where Sum_ready=1. The next cycle is IDLE and a new Start can be accepted then: one dead cycle between windows.
- Sum_ready asserted before DONE has no effect.

## Structure
- Shared package: state enum (IDLE/ACCUM/DONE) and the ACC_W/CNT_W width functions, so that downstream blocks size their ports identically.
- One sub-module: the combinational two-operand adder (existing `Suma`, same SAMPLES/OSF/SIZE parameters), instantiated once. Operand A is the accumulator; operand B is Din zero-extended to ACC_W.
- The FSM, counter and accumulator register live in sumatoria_ctrl.

## Test plan
Parameters for all scenarios: SAMPLES=4, OSF=2, SIZE=7 (N=8, ACC_W=11).
- Reset and idle: hold RST 3 cycles, then idle 5 cycles -> all outputs 0; Din_valid=1 is not accepted (Din_ready=0).
- Basic window: Start, then Din=1..8 on consecutive cycles -> Sum_valid rises the cycle after the 8th sample with Sum=36, Count=8; Sum_ready=1 -> IDLE the next cycle.
- Max value: 8 samples of 255 -> Sum=2040 (fits in 11 bits, no wrap); Busy high from the cycle after Start through DONE.
- Gapped input and backpressure: Din_valid toggled 1/0 with samples of 10 -> Sum=80 after 16 cycles; Sum_ready held 0 for 5 cycles -> Sum and Sum_valid stable throughout.
- Ignored Start: pulse Start mid-window and during DONE -> accumulation unaffected, final Sum correct, no extra window begins.
- Reset mid-window: after 5 samples of 100, assert RST -> next cycle IDLE, Count=0, Sum=0; a new window of 8 samples of 3 -> Sum=24.

Source files
------------

// File: rtl/sumatoria_ctrl_pkg.sv
// Shared types and width helpers for the window-sum controller and its consumers.
package sumatoria_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Accumulator / result width: a full window of max-valued samples never wraps.
  function automatic int acc_w(int samples, int osf, int size);
    return $clog2(samples * osf) + size + 1;
  endfunction

  // Sample counter width: must be able to hold N itself.
  function automatic int cnt_w(int samples, int osf);
    return $clog2(samples * osf) + 1;
  endfunction

endpackage

// File: rtl/sumatoria_ctrl_if.sv
// Sample-in / total-out handshake bundle of the window-sum controller.
interface sumatoria_ctrl_if #(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  parameter int SIZE    = 7
) ();
  localparam int ACC_W = sumatoria_ctrl_pkg::acc_w(SAMPLES, OSF, SIZE);
  localparam int CNT_W = sumatoria_ctrl_pkg::cnt_w(SAMPLES, OSF);

  logic             Start;
  logic [SIZE:0]    Din;
  logic             Din_valid;
  logic             Din_ready;
  logic [ACC_W-1:0] Sum;
  logic             Sum_valid;
  logic             Sum_ready;
  logic             Busy;
  logic [CNT_W-1:0] Count;

  // Upstream/downstream side driving the controller.
  modport master (
    output Start, Din, Din_valid, Sum_ready,
    input  Din_ready, Sum, Sum_valid, Busy, Count
  );

  // Controller side.
  modport slave (
    input  Start, Din, Din_valid, Sum_ready,
    output Din_ready, Sum, Sum_valid, Busy, Count
  );
endinterface

// File: rtl/sumatoria_ctrl_suma.sv
// Shared two-operand adder; result is one bit wider than the operands.
module Suma
  import sumatoria_ctrl_pkg::*;
#(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  parameter int SIZE    = 7
) (
  input  logic [acc_w(SAMPLES, OSF, SIZE)-1:0] A,
  input  logic [acc_w(SAMPLES, OSF, SIZE)-1:0] B,
  output logic [acc_w(SAMPLES, OSF, SIZE):0]   S
);
  // Plain unsigned add with carry out.
  always_comb S = {1'b0, A} + {1'b0, B};
endmodule

// File: rtl/sumatoria_ctrl.sv
// Window-sum sequencer: accumulates N = SAMPLES*OSF samples through one adder,
// then holds the total with a valid/ready handshake.
module sumatoria_ctrl
  import sumatoria_ctrl_pkg::*;
#(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  parameter int SIZE    = 7
) (
  input  logic             CLK,
  input  logic             RST,
  sumatoria_ctrl_if.slave  b
);
  localparam int N     = SAMPLES * OSF;
  localparam int ACC_W = acc_w(SAMPLES, OSF, SIZE);
  localparam int CNT_W = cnt_w(SAMPLES, OSF);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             din_rdy, sum_vld, busy;
  logic [ACC_W-1:0] din_ext;
  logic [ACC_W:0]   sum_full;
  logic             carry_unused;
  logic             accept;

  // The carry cannot be set for a power-of-two window, so it is dropped.
  assign din_ext      = {{(ACC_W-SIZE-1){1'b0}}, b.Din};
  assign carry_unused = sum_full[ACC_W];
  assign accept       = b.Din_valid && din_rdy;

  Suma #(.SAMPLES(SAMPLES), .OSF(OSF), .SIZE(SIZE)) u_suma (
    .A (acc),
    .B (din_ext),
    .S (sum_full)
  );

  // Control FSM with registered handshake outputs, counter and accumulator.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      din_rdy <= 1'b0;
      sum_vld <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (b.Start) begin
          state   <= ACCUM;
          acc     <= '0;
          cnt     <= '0;
          din_rdy <= 1'b1;
          busy    <= 1'b1;
        end
        ACCUM: if (accept) begin
          acc <= sum_full[ACC_W-1:0];
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state   <= DONE;
            din_rdy <= 1'b0;
            sum_vld <= 1'b1;
          end
        end
        DONE: if (b.Sum_ready) begin
          state   <= IDLE;
          sum_vld <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          din_rdy <= 1'b0;
          sum_vld <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign b.Din_ready = din_rdy;
  assign b.Sum       = acc;
  assign b.Sum_valid = sum_vld;
  assign b.Busy      = busy;
  assign b.Count     = cnt;
endmodule

// File: tb/tb_sumatoria_ctrl.sv
// Randomized + directed bench for sumatoria_ctrl against a queue-based window model.
module tb_sumatoria_ctrl;
  localparam int SAMPLES = 4;
  localparam int OSF     = 2;
  localparam int SIZE    = 7;
  localparam int N       = SAMPLES * OSF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sumatoria_ctrl_if #(.SAMPLES(SAMPLES), .OSF(OSF), .SIZE(SIZE)) bus ();

  sumatoria_ctrl #(.SAMPLES(SAMPLES), .OSF(OSF), .SIZE(SIZE)) dut (
    .CLK (clk),
    .RST (rst),
    .b   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: 0 = no window, 1 = collecting, 2 = total waiting for pickup.
  int m_mode = 0;
  int m_q[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int qsum();
    int s = 0;
    foreach (m_q[i]) s += m_q[i];
    return s;
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic step(input bit r, input bit st, input bit dv, input int din, input bit sr);
    rst           = r;
    bus.Start     = st;
    bus.Din_valid = dv;
    bus.Din       = din[SIZE:0];
    bus.Sum_ready = sr;
    @(posedge clk);
    if (r) begin
      m_mode = 0;
      m_q.delete();
    end else if (m_mode == 0) begin
      if (st) begin
        m_mode = 1;
        m_q.delete();
      end
    end else if (m_mode == 1) begin
      if (dv) begin
        m_q.push_back(din & 255);
        if (m_q.size() == N) m_mode = 2;
      end
    end else if (sr) begin
      m_mode = 0;
    end
    @(negedge clk);
    chk("din_ready", bus.Din_ready, (m_mode == 1) ? 1 : 0);
    chk("sum_valid", bus.Sum_valid, (m_mode == 2) ? 1 : 0);
    chk("busy",      bus.Busy,      (m_mode != 0) ? 1 : 0);
    chk("count",     bus.Count,     m_q.size());
    chk("sum",       bus.Sum,       qsum());
  endtask

  initial begin
    // Reset held 3 cycles, then idle with Din_valid high: nothing accepted.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 55, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 55, 0);
    chk("idle_sum0", bus.Sum, 0);

    // Basic window 1..8.
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= N; i++) step(0, 0, 1, i, 0);
    chk("basic_sum36", bus.Sum, 36);
    chk("basic_cnt8", bus.Count, 8);
    step(0, 0, 0, 0, 1);
    chk("basic_idle", bus.Busy, 0);

    // Max-valued samples.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 0, 1, 255, 0);
    chk("max_sum2040", bus.Sum, 2040);
    step(0, 0, 0, 0, 1);

    // Gapped input then backpressure.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 2 * N; i++) step(0, 0, (i % 2) == 0, 10, 0);
    chk("gap_sum80", bus.Sum, 80);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    chk("bp_sum80", bus.Sum, 80);
    chk("bp_valid", bus.Sum_valid, 1);
    step(0, 0, 0, 0, 1);

    // Start pulses mid-window and during DONE; early Sum_ready during ACCUM.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, (i == 3), 1, 5, (i == 5));
    chk("ign_sum40", bus.Sum, 40);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("ign_no_restart", bus.Busy, 0);

    // Reset mid-window, then a fresh window.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 100, 0);
    step(1, 0, 1, 100, 0);
    chk("rst_cnt0", bus.Count, 0);
    chk("rst_sum0", bus.Sum, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 0, 1, 3, 0);
    chk("rst_sum24", bus.Sum, 24);
    step(0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
           ($urandom_range(0, 2) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
